// File: rtl/debug_uart_tx_pkg.sv
// Shared definitions for the debug UART transmitter: frame constants, default
// line rate, FSM state encoding and the bit-period rounding helper.
package debug_uart_tx_pkg;

  localparam int unsigned DEF_CLK_FREQ_HZ = 12_000_000;
  localparam int unsigned DEF_BAUD        = 115_200;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  // Round to the nearest whole clock count per bit.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/debug_uart_tx_sync_fifo.sv
// Single-clock FIFO with registered storage, synchronous active-low reset and
// an occupancy count one bit wider than the pointers.
module debug_uart_tx_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];

  // A push into a full FIFO is dropped even if a pop frees a slot on the same edge.
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; pointers and count define
  // which entries are valid, and an unreset array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/debug_uart_tx.sv
// Debug UART transmitter: buffers the core's byte stream in a FIFO and sends
// each byte as an 8N1 frame, LSB first, with back-to-back frames contiguous.
module debug_uart_tx
  import debug_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int unsigned BAUD        = DEF_BAUD,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_Data,
  input  logic       tx_DataValid,
  output logic       tx_Ready,
  output logic       tx_Busy,
  output logic       tx_Overflow,
  output logic       tx
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int unsigned BAUD_W       = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W        = $clog2(DATA_BITS);
  localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_chk_baud
    $error("debug_uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("debug_uart_tx: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  uart_state_e       r_state;
  uart_state_e       w_state_nxt;
  logic [BAUD_W-1:0] r_baud_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [7:0]        r_shift;
  logic              r_tx;
  logic              r_busy;
  logic              r_overflow;

  logic              w_push;
  logic              w_pop;
  logic [7:0]        w_fifo_data;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic              w_baud_done;

  // Ready is forced low in reset so pushes during reset never land.
  assign tx_Ready    = resetn & (w_count != CNT_W'(FIFO_DEPTH));
  assign w_push      = tx_DataValid & tx_Ready;
  assign w_baud_done = (r_baud_cnt == BAUD_LAST);

  assign tx          = r_tx;
  assign tx_Busy     = r_busy;
  assign tx_Overflow = r_overflow;

  debug_uart_tx_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_data  (tx_Data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= UART_IDLE;
    else         r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      UART_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = UART_START;
        end
      end
      UART_START: begin
        if (w_baud_done) w_state_nxt = UART_DATA;
      end
      UART_DATA: begin
        if (w_baud_done && r_bit_cnt == BIT_LAST) w_state_nxt = UART_STOP;
      end
      UART_STOP: begin
        // Chain straight into the next start bit when more bytes are waiting.
        if (w_baud_done) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = UART_START;
          end else begin
            w_state_nxt = UART_IDLE;
          end
        end
      end
      default: w_state_nxt = UART_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != UART_IDLE);

      if (tx_DataValid && w_full) r_overflow <= 1'b1;

      if (r_state == UART_IDLE || w_baud_done) r_baud_cnt <= '0;
      else                                     r_baud_cnt <= r_baud_cnt + 1'b1;

      // tx is loaded with the value of the upcoming bit at each boundary.
      if (w_pop) begin
        r_shift   <= w_fifo_data;
        r_tx      <= 1'b0;
        r_bit_cnt <= '0;
      end else if (w_baud_done) begin
        case (r_state)
          UART_START: r_tx <= r_shift[0];
          UART_DATA: begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == BIT_LAST) begin
              r_tx <= 1'b1;
            end else begin
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end
          UART_STOP: r_tx <= 1'b1;
          default:   r_tx <= r_tx;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_debug_uart_tx.sv
// Scoreboard bench for debug_uart_tx: stimulus queues expected bytes, a per-DUT
// monitor checks every cycle of each frame on the serial line against them.
module tb_debug_uart_tx;

  logic       clk;
  logic       resetn;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ready_w [2];
  logic       busy_w  [2];
  logic       ovf_w   [2];
  logic       tx_w    [2];

  int         cyc;
  int         total;
  int         bad;
  int         frames_done [2];
  int         started     [2];
  int         start_log [$];
  logic [7:0] sb_q [2][$];

  debug_uart_tx #(.CLK_FREQ_HZ(1000), .BAUD(100), .FIFO_DEPTH(16)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .tx_Data      (data_a),
    .tx_DataValid (valid_a),
    .tx_Ready     (ready_w[0]),
    .tx_Busy      (busy_w[0]),
    .tx_Overflow  (ovf_w[0]),
    .tx           (tx_w[0])
  );

  debug_uart_tx #(.CLK_FREQ_HZ(1000), .BAUD(300), .FIFO_DEPTH(16)) dut_b (
    .clk          (clk),
    .resetn       (resetn),
    .tx_Data      (data_b),
    .tx_DataValid (valid_b),
    .tx_Ready     (ready_w[1]),
    .tx_Busy      (busy_w[1]),
    .tx_Overflow  (ovf_w[1]),
    .tx           (tx_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] b, input bit accept);
    data_a  = b;
    valid_a = 1'b1;
    if (accept) sb_q[0].push_back(b);
    step();
    valid_a = 1'b0;
  endtask

  task automatic wait_frames(input int m, input int n, input int budget, input string name);
    int b;
    b = budget;
    while (frames_done[m] < n && b > 0) begin
      step();
      b--;
    end
    check(name, frames_done[m], n);
  endtask

  // Receiver model: compares the whole frame waveform and busy flag cycle by cycle.
  task automatic run_monitor(input int m);
    int         cpb;
    int         n_err;
    bit         have;
    bit         aborted;
    logic [7:0] exp_b;
    logic [7:0] got;
    logic [9:0] fr;
    cpb = (m == 0) ? 10 : 3;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && tx_w[m] === 1'b0) begin
        started[m]++;
        if (m == 0) start_log.push_back(cyc);
        have    = (sb_q[m].size() != 0);
        exp_b   = have ? sb_q[m].pop_front() : 8'h00;
        fr      = {1'b1, exp_b, 1'b0};
        got     = 8'h00;
        n_err   = 0;
        aborted = 1'b0;
        for (int i = 0; i < 10 * cpb; i++) begin
          if (i != 0) @(negedge clk);
          if (resetn !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (tx_w[m] !== fr[i / cpb] || busy_w[m] !== 1'b1) n_err++;
          if ((i % cpb) == cpb / 2 && i / cpb >= 1 && i / cpb <= 8) got[i / cpb - 1] = tx_w[m];
        end
        if (!aborted) begin
          check(m == 0 ? "frame_expected_a" : "frame_expected_b", have, 1'b1);
          check(m == 0 ? "frame_byte_a" : "frame_byte_b", got, exp_b);
          check(m == 0 ? "frame_wave_errs_a" : "frame_wave_errs_b", n_err, 0);
          frames_done[m]++;
        end
      end
    end
  endtask

  initial begin
    fork
      run_monitor(0);
      run_monitor(1);
    join_none
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n0, e_edge, s, f0;
    total   = 0;
    bad     = 0;
    resetn  = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    data_a  = 8'h00;
    data_b  = 8'h00;
    frames_done = '{0, 0};
    started     = '{0, 0};

    // Reset state; a push strobe during reset must be ignored.
    repeat (3) step();
    data_a = 8'h99; valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    check("rst_tx", tx_w[0], 1'b1);
    check("rst_busy", busy_w[0], 1'b0);
    check("rst_overflow", ovf_w[0], 1'b0);
    check("rst_ready_low", ready_w[0], 1'b0);
    resetn = 1'b1;
    #1;
    check("ready_after_reset", ready_w[0], 1'b1);
    repeat (20) step();
    check("no_frame_from_reset_push", started[0], 0);

    // Test 1: 0x55, start bit one edge after acceptance, busy exactly one frame.
    n0     = start_log.size();
    e_edge = cyc + 1;
    push_a(8'h55, 1'b1);
    wait_frames(0, 1, 200, "t1_frames");
    check("t1_latency", start_log[n0] - e_edge, 1);
    check("t1_busy_after", busy_w[0], 1'b0);
    check("t1_tx_idle_after", tx_w[0], 1'b1);

    // Test 2: two bytes on consecutive edges run back to back.
    repeat (5) step();
    n0 = start_log.size();
    push_a(8'hA5, 1'b1);
    push_a(8'hC3, 1'b1);
    wait_frames(0, 3, 300, "t2_frames");
    check("t2_gap", start_log[n0 + 1] - start_log[n0], 100);

    // Test 5: all-zero and all-one data bytes.
    repeat (5) step();
    n0 = start_log.size();
    push_a(8'h00, 1'b1);
    push_a(8'hFF, 1'b1);
    wait_frames(0, 5, 300, "t5_frames");
    check("t5_frame_len", start_log[n0 + 1] - start_log[n0], 100);

    // Test 3: 18 pushes from idle; 17 fit, the last is dropped and flags overflow.
    repeat (5) step();
    check("t3_overflow_before", ovf_w[0], 1'b0);
    for (int i = 0; i < 18; i++) begin
      if (i == 16) check("t3_ready_after_16", ready_w[0], 1'b1);
      if (i == 17) check("t3_ready_after_17", ready_w[0], 1'b0);
      push_a(8'h10 + 8'(i), i < 17);
    end
    check("t3_overflow_set", ovf_w[0], 1'b1);
    wait_frames(0, 22, 1900, "t3_frames");
    repeat (50) step();
    check("t3_frame_count", started[0], 22);
    check("t3_overflow_sticky", ovf_w[0], 1'b1);

    // Test 4: one-cycle reset during data bit 4 of 0xF0 with 3 bytes queued.
    n0 = started[0];
    push_a(8'hF0, 1'b1);
    push_a(8'hA1, 1'b1);
    push_a(8'hB2, 1'b1);
    push_a(8'hC3, 1'b1);
    for (int b = 0; b < 50 && started[0] == n0; b++) step();
    check("t4_started", started[0], n0 + 1);
    s = start_log[start_log.size() - 1];
    while (cyc < s + 54) step();
    resetn = 1'b0;
    step();
    check("t4_tx_after_reset", tx_w[0], 1'b1);
    check("t4_busy_after_reset", busy_w[0], 1'b0);
    check("t4_overflow_cleared", ovf_w[0], 1'b0);
    sb_q[0].delete();
    resetn = 1'b1;
    repeat (300) step();
    check("t4_no_more_frames", started[0], n0 + 1);
    f0 = frames_done[0];
    push_a(8'h3C, 1'b1);
    wait_frames(0, f0 + 1, 200, "t4_clean_frame");

    // Test 6: BAUD=300 at 1 kHz rounds to 3 clocks per bit.
    f0 = frames_done[1];
    data_b  = 8'h5A;
    valid_b = 1'b1;
    sb_q[1].push_back(8'h5A);
    step();
    valid_b = 1'b0;
    wait_frames(1, f0 + 1, 60, "t6_frames");
    check("t6_busy_after", busy_w[1], 1'b0);
    check("t6_tx_idle_after", tx_w[1], 1'b1);

    repeat (5) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
